// File: rtl/memory_buffer_pp_if.sv
// rtl/memory_buffer_pp_if.sv - mode, host, parallel and ping-pong signal bundle for memory_buffer_pp
interface memory_buffer_pp_if #(
  parameter int N_BANK = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic [1:0]                 mode_in;
  logic                       mode_load;
  logic [1:0]                 mode;
  logic                       busy;
  logic [$clog2(N_BANK)-1:0]  h_bank;
  logic                       h_w_en;
  logic [ADDR_W-1:0]          h_w_addr;
  logic [DATA_W-1:0]          h_w_data;
  logic                       h_r_en;
  logic [ADDR_W-1:0]          h_r_addr;
  logic [DATA_W-1:0]          h_r_data;
  logic                       h_r_valid;
  logic                       p_w_en;
  logic [ADDR_W-1:0]          p_w_addr;
  logic [N_BANK*DATA_W-1:0]   p_w_data;
  logic                       p_r_en;
  logic [ADDR_W-1:0]          p_r_addr;
  logic [N_BANK*DATA_W-1:0]   p_r_data;
  logic                       p_r_valid;
  logic                       pp_swap;
  logic                       pp_half;
  logic                       err;

  modport master (
    output mode_in, mode_load, h_bank, h_w_en, h_w_addr, h_w_data, h_r_en, h_r_addr,
           p_w_en, p_w_addr, p_w_data, p_r_en, p_r_addr, pp_swap,
    input  mode, busy, h_r_data, h_r_valid, p_r_data, p_r_valid, pp_half, err
  );

  modport slave (
    input  mode_in, mode_load, h_bank, h_w_en, h_w_addr, h_w_data, h_r_en, h_r_addr,
           p_w_en, p_w_addr, p_w_data, p_r_en, p_r_addr, pp_swap,
    output mode, busy, h_r_data, h_r_valid, p_r_data, p_r_valid, pp_half, err
  );
endinterface

// File: rtl/memory_buffer_pp.sv
// rtl/memory_buffer_pp.sv - N-bank buffer with host, parallel and ping-pong access modes
module memory_buffer_pp #(
  parameter int N_BANK = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input logic               clk,
  input logic               rst,
  memory_buffer_pp_if.slave bus
);
  localparam int BANK_W = $clog2(N_BANK);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [1:0] MODE_HOST = 2'd0;
  localparam logic [1:0] MODE_PP   = 2'd2;
  localparam logic [1:0] MODE_BAD  = 2'd3;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                   state, state_nx;
  logic [1:0]               mode_q, mode_nx, pend_q, pend_nx;
  logic                     half_q, half_nx, err_q, err_nx;
  logic                     h_wr, h_rd, p_wr, p_rd, inflight, any_req;
  logic                     s1_h_valid, s1_p_valid;
  logic [BANK_W-1:0]        s1_bank;
  logic [ADDR_W-1:0]        p_wa, p_ra;
  logic [N_BANK*DATA_W-1:0] rd_bus;
  logic                     h_r_valid_q, p_r_valid_q;
  logic [DATA_W-1:0]        h_r_data_q;
  logic [N_BANK*DATA_W-1:0] p_r_data_q;

  assign inflight = s1_h_valid | s1_p_valid;
  assign any_req  = bus.h_w_en | bus.h_r_en | bus.p_w_en | bus.p_r_en | bus.mode_load;

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    pend_nx  = pend_q;
    half_nx  = half_q;
    err_nx   = 1'b0;
    h_wr     = 1'b0;
    h_rd     = 1'b0;
    p_wr     = 1'b0;
    p_rd     = 1'b0;
    case (state)
      RUN: begin
        if (mode_q == MODE_HOST) begin
          h_wr   = bus.h_w_en;
          h_rd   = bus.h_r_en;
          err_nx = bus.p_w_en | bus.p_r_en;
        end else begin
          p_wr   = bus.p_w_en;
          p_rd   = bus.p_r_en;
          err_nx = bus.h_w_en | bus.h_r_en;
        end
        // a read accepted this cycle still counts as in flight for the mode switch
        if (bus.mode_load) begin
          if (bus.mode_in == MODE_BAD) begin
            err_nx = 1'b1;
          end else if (inflight || h_rd || p_rd) begin
            state_nx = DRAIN;
            pend_nx  = bus.mode_in;
          end else begin
            mode_nx = bus.mode_in;
          end
        end else if (bus.pp_swap && mode_q == MODE_PP) begin
          half_nx = ~half_q;
        end
      end
      DRAIN: begin
        err_nx = any_req;
        if (!inflight) begin
          state_nx = RUN;
          mode_nx  = pend_q;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      mode_q <= MODE_HOST;
      pend_q <= MODE_HOST;
      half_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      mode_q <= mode_nx;
      pend_q <= pend_nx;
      half_q <= half_nx;
      err_q  <= err_nx;
    end
  end

  // ping-pong steers the address MSB: writes into the current half, reads from the other
  always_comb begin
    p_wa = bus.p_w_addr;
    p_ra = bus.p_r_addr;
    if (mode_q == MODE_PP) begin
      p_wa[ADDR_W-1] = half_q;
      p_ra[ADDR_W-1] = ~half_q;
    end
  end

  for (genvar i = 0; i < N_BANK; i++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              sel, we, re;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] wd;

    assign sel = (bus.h_bank == BANK_W'(i));
    assign we  = p_wr | (h_wr & sel);
    assign re  = p_rd | (h_rd & sel);
    assign wa  = h_wr ? bus.h_w_addr : p_wa;
    assign ra  = h_rd ? bus.h_r_addr : p_ra;
    assign wd  = h_wr ? bus.h_w_data : bus.p_w_data[i*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)     rd_q <= '0;
      else if (re) rd_q <= mem[ra];
    end

    assign rd_bus[i*DATA_W +: DATA_W] = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_h_valid  <= 1'b0;
      s1_p_valid  <= 1'b0;
      s1_bank     <= '0;
      h_r_valid_q <= 1'b0;
      p_r_valid_q <= 1'b0;
      h_r_data_q  <= '0;
      p_r_data_q  <= '0;
    end else begin
      s1_h_valid  <= h_rd;
      s1_p_valid  <= p_rd;
      s1_bank     <= bus.h_bank;
      h_r_valid_q <= s1_h_valid;
      p_r_valid_q <= s1_p_valid;
      if (s1_h_valid) h_r_data_q <= rd_bus[s1_bank*DATA_W +: DATA_W];
      if (s1_p_valid) p_r_data_q <= rd_bus;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.busy      = (state == DRAIN);
  assign bus.pp_half   = half_q;
  assign bus.err       = err_q;
  assign bus.h_r_data  = h_r_data_q;
  assign bus.h_r_valid = h_r_valid_q;
  assign bus.p_r_data  = p_r_data_q;
  assign bus.p_r_valid = p_r_valid_q;
endmodule

// File: tb/tb_memory_buffer_pp.sv
// tb/tb_memory_buffer_pp.sv - scoreboard bench for memory_buffer_pp against a behavioural model
module tb_memory_buffer_pp;
  localparam int NB = 4;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int HALF = 32;

  typedef struct { int due; logic [63:0] data; } rd_t;
  typedef struct { int due; logic [1:0] mode; logic half; logic busy; logic err; } snap_t;

  logic clk = 1'b0;
  logic rst;
  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  rd_t   hq[$];
  rd_t   pq[$];
  snap_t snap_q[$];
  rd_t   mr;
  snap_t ms;

  logic [DW-1:0] m_mem [NB][DEPTH];
  logic [1:0]    m_mode, m_pend;
  bit            m_half, m_drain;
  int            rd_due_max;
  logic [DW-1:0] keep;

  memory_buffer_pp_if #(.N_BANK(NB), .DATA_W(DW), .ADDR_W(AW)) bus ();

  memory_buffer_pp #(.N_BANK(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic clr();
    bus.mode_in = 2'd0; bus.mode_load = 1'b0; bus.h_bank = '0;
    bus.h_w_en = 1'b0; bus.h_w_addr = '0; bus.h_w_data = '0;
    bus.h_r_en = 1'b0; bus.h_r_addr = '0;
    bus.p_w_en = 1'b0; bus.p_w_addr = '0; bus.p_w_data = '0;
    bus.p_r_en = 1'b0; bus.p_r_addr = '0; bus.pp_swap = 1'b0;
  endtask

  function automatic int phys(input int addr, input bit upper);
    if (m_mode == 2'd2) return (upper ? HALF : 0) + (addr % HALF);
    return addr;
  endfunction

  // Predicts the effect of the current inputs at the coming rising edge
  task automatic model_edge();
    int e, ra, wa;
    bit ev_err, rd_now;
    logic [63:0] rv;
    e = edge_n + 1; ev_err = 1'b0; rd_now = 1'b0; rv = '0;
    if (!m_drain) begin
      if (m_mode == 2'd0) begin
        ev_err = bus.p_w_en || bus.p_r_en;
        if (bus.h_r_en) begin
          rv[DW-1:0] = m_mem[bus.h_bank][bus.h_r_addr];
          hq.push_back('{due: e + 1, data: rv});
          rd_now = 1'b1;
        end
        if (bus.h_w_en) m_mem[bus.h_bank][bus.h_w_addr] = bus.h_w_data;
      end else begin
        ev_err = bus.h_w_en || bus.h_r_en;
        if (bus.p_r_en) begin
          ra = phys(int'(bus.p_r_addr), !m_half);
          for (int i = 0; i < NB; i++) rv[i*DW +: DW] = m_mem[i][ra];
          pq.push_back('{due: e + 1, data: rv});
          rd_now = 1'b1;
        end
        if (bus.p_w_en) begin
          wa = phys(int'(bus.p_w_addr), m_half);
          for (int i = 0; i < NB; i++) m_mem[i][wa] = bus.p_w_data[i*DW +: DW];
        end
      end
      if (bus.mode_load) begin
        if (bus.mode_in == 2'd3) ev_err = 1'b1;
        else if (rd_due_max >= e || rd_now) begin m_drain = 1'b1; m_pend = bus.mode_in; end
        else m_mode = bus.mode_in;
      end else if (bus.pp_swap && m_mode == 2'd2) begin
        m_half = !m_half;
      end
      if (rd_now) rd_due_max = e + 1;
    end else begin
      ev_err = bus.h_w_en || bus.h_r_en || bus.p_w_en || bus.p_r_en || bus.mode_load;
      if (rd_due_max < e) begin m_mode = m_pend; m_drain = 1'b0; end
    end
    snap_q.push_back('{due: e, mode: m_mode, half: m_half, busy: m_drain, err: ev_err});
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic load_mode(input logic [1:0] m);
    clr(); bus.mode_load = 1'b1; bus.mode_in = m; step(); clr();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (snap_q.size() > 0 && snap_q[0].due == edge_n) begin
        ms = snap_q.pop_front();
        chk("mode", 64'(bus.mode), 64'(ms.mode));
        chk("busy", 64'(bus.busy), 64'(ms.busy));
        chk("pp_half", 64'(bus.pp_half), 64'(ms.half));
        chk("err", 64'(bus.err), 64'(ms.err));
      end
      if (hq.size() > 0 && hq[0].due == edge_n) begin
        mr = hq.pop_front();
        chk("h_r_valid", 64'(bus.h_r_valid), 64'd1);
        chk("h_r_data", 64'(bus.h_r_data), mr.data);
      end else begin
        chk("h_r_valid_idle", 64'(bus.h_r_valid), 64'd0);
      end
      if (pq.size() > 0 && pq[0].due == edge_n) begin
        mr = pq.pop_front();
        chk("p_r_valid", 64'(bus.p_r_valid), 64'd1);
        chk("p_r_data", 64'(bus.p_r_data), mr.data);
      end else begin
        chk("p_r_valid_idle", 64'(bus.p_r_valid), 64'd0);
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    m_mode = 2'd0; m_pend = 2'd0; m_half = 1'b0; m_drain = 1'b0; rd_due_max = -100;
    repeat (3) @(negedge clk);
    chk("rst_mode", 64'(bus.mode), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pp_half", 64'(bus.pp_half), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_h_r_valid", 64'(bus.h_r_valid), 64'd0);
    chk("rst_p_r_valid", 64'(bus.p_r_valid), 64'd0);
    chk("rst_h_r_data", 64'(bus.h_r_data), 64'd0);
    chk("rst_p_r_data", bus.p_r_data, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // fill every word of every bank so all later reads are predictable
    load_mode(2'd1);
    for (int a = 0; a < DEPTH; a++) begin
      bus.p_w_en = 1'b1; bus.p_w_addr = AW'(a); bus.p_w_data = {$urandom, $urandom};
      step();
    end
    clr();

    // parallel write/readback with slice i = 0x100+i
    bus.p_w_en = 1'b1; bus.p_w_addr = 6'd7;
    for (int i = 0; i < NB; i++) bus.p_w_data[i*DW +: DW] = DW'(16'h100 + i);
    step(); clr();
    bus.p_r_en = 1'b1; bus.p_r_addr = 6'd7; step(); clr();
    chk("par_valid_t1", 64'(bus.p_r_valid), 64'd0);
    step();
    chk("par_valid_t2", 64'(bus.p_r_valid), 64'd1);
    chk("par_data_t2", bus.p_r_data, 64'h0103_0102_0101_0100);

    // illegal requests
    bus.h_w_en = 1'b1; bus.h_w_addr = 6'd9; bus.h_w_data = 16'hDEAD; step(); clr();
    chk("host_wr_in_par_err", 64'(bus.err), 64'd1);
    load_mode(2'd3);
    chk("mode3_err", 64'(bus.err), 64'd1);
    chk("mode3_unchanged", 64'(bus.mode), 64'd1);

    // host bank targeting
    load_mode(2'd0);
    bus.h_w_en = 1'b1; bus.h_bank = 2'd2; bus.h_w_addr = 6'd5; bus.h_w_data = 16'h5555; step();
    bus.h_bank = 2'd3; bus.h_w_data = 16'h1234; step(); clr();
    bus.h_r_en = 1'b1; bus.h_bank = 2'd3; bus.h_r_addr = 6'd5; step(); clr();
    chk("host_valid_t1", 64'(bus.h_r_valid), 64'd0);
    step();
    chk("host_valid_t2", 64'(bus.h_r_valid), 64'd1);
    chk("host_data_t2", 64'(bus.h_r_data), 64'h1234);
    bus.h_r_en = 1'b1; bus.h_bank = 2'd2; bus.h_r_addr = 6'd5; step(); clr(); step();
    chk("host_other_bank", 64'(bus.h_r_data != 16'h1234), 64'd1);

    // ping-pong swap
    load_mode(2'd2);
    bus.p_w_en = 1'b1; bus.p_w_addr = 6'd1; bus.p_w_data = {4{16'hAAAA}}; step(); clr();
    bus.pp_swap = 1'b1; step(); clr();
    chk("pp_half_after_swap", 64'(bus.pp_half), 64'd1);
    bus.p_r_en = 1'b1; bus.p_r_addr = 6'd1; step(); clr(); step();
    chk("pp_read_data", bus.p_r_data, {4{16'hAAAA}});

    // drain on mode change with a read in flight
    keep = m_mem[0][HALF + 3];
    bus.p_r_en = 1'b1; bus.p_r_addr = 6'd3; bus.mode_load = 1'b1; bus.mode_in = 2'd0; step(); clr();
    chk("drain_busy", 64'(bus.busy), 64'd1);
    bus.p_w_en = 1'b1; bus.p_w_addr = 6'd3; bus.p_w_data = {4{16'hBEEF}}; step(); clr();
    chk("drain_wr_err", 64'(bus.err), 64'd1);
    chk("drain_p_r_valid", 64'(bus.p_r_valid), 64'd1);
    step();
    chk("drain_mode", 64'(bus.mode), 64'd0);
    chk("drain_busy_clear", 64'(bus.busy), 64'd0);
    bus.h_r_en = 1'b1; bus.h_bank = 2'd0; bus.h_r_addr = AW'(HALF + 3); step(); clr(); step();
    chk("drain_no_write", 64'(bus.h_r_data), 64'(keep));

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bus.mode_load = ($urandom_range(0, 15) == 0);
      bus.mode_in   = 2'($urandom_range(0, 3));
      bus.h_bank    = 2'($urandom_range(0, NB - 1));
      bus.h_w_en    = 1'($urandom_range(0, 1));
      bus.h_w_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.h_w_data  = DW'($urandom);
      bus.h_r_en    = 1'($urandom_range(0, 1));
      bus.h_r_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.p_w_en    = 1'($urandom_range(0, 1));
      bus.p_w_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.p_w_data  = {$urandom, $urandom};
      bus.p_r_en    = 1'($urandom_range(0, 1));
      bus.p_r_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.pp_swap   = ($urandom_range(0, 7) == 0);
      step();
    end
    clr();
    repeat (4) step();
    chk("reads_drained", 64'(hq.size() + pq.size()), 64'd0);

    // reset one cycle after a parallel read
    load_mode(2'd1);
    step();
    chk("pre_reset_mode", 64'(bus.mode), 64'd1);
    bus.p_r_en = 1'b1; bus.p_r_addr = 6'd2; step(); clr();
    mon_en = 1'b0;
    rst = 1'b1;
    hq.delete(); pq.delete(); snap_q.delete();
    @(negedge clk);
    chk("rst_mid_p_r_valid", 64'(bus.p_r_valid), 64'd0);
    rst = 1'b0;
    m_mode = 2'd0; m_half = 1'b0; m_drain = 1'b0; rd_due_max = -100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_p_r_valid", 64'(bus.p_r_valid), 64'd0);
      chk("post_rst_mode", 64'(bus.mode), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
